// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl
//   Upstream loader for an 8-bit element register bank (one register per
//   matrix element, shared d_in, one enable per register). Accepts a
//   valid/ready stream of elements and writes them row-major into the bank.
//   A one-cycle bank clear is issued at the start of every load. A one-cycle
//   done pulse is issued once every element has been stored.
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   clear      in   1      synchronous active-high reset, highest priority
//   start      in   1      begin a load (honoured only while idle)
//   abort      in   1      abandon an in-progress load
//   in_valid   in   1      in_data carries an element
//   in_ready   out  1      an element is accepted this cycle (state LOAD)
//   in_data    in   8      element value
//   reg_clear  out  1      one-cycle clear pulse to the bank
//   wr_en      out  N      one-hot write enable, bit i -> register i
//   wr_data    out  8      shared data input for all bank registers
//   row        out  IW     row index of the next element to accept
//   col        out  IW     column index of the next element to accept
//   busy       out  1      high in CLR, LOAD and FLUSH
//   done       out  1      one-cycle pulse, bank fully loaded
module matrix_load_ctrl #(
  parameter  int ROWS = 2,
  parameter  int COLS = 2,
  localparam int N    = ROWS * COLS,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          reg_clear,
  output logic [N-1:0]  wr_en,
  output logic [7:0]    wr_data,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);
  localparam logic [IW-1:0] LAST_COL = IW'(COLS - 1);

  state_t        state_q,     state_d;
  logic          reg_clear_q, reg_clear_d;
  logic [N-1:0]  wr_en_q,     wr_en_d;
  logic [7:0]    wr_data_q,   wr_data_d;
  logic [IW-1:0] row_q,       row_d;
  logic [IW-1:0] col_q,       col_d;
  logic          done_q,      done_d;

  logic [IW-1:0] lin_idx;

  always_comb begin
    state_d     = state_q;
    reg_clear_d = 1'b0;
    wr_en_d     = '0;
    wr_data_d   = wr_data_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    lin_idx     = IW'(int'(row_q) * COLS + int'(col_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLR;
          reg_clear_d = 1'b1;
          row_d       = '0;
          col_d       = '0;
        end
      end

      S_CLR: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // abort beats a simultaneous beat: nothing is written
        if (abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else if (in_valid) begin
          wr_en_d   = N'(1) << lin_idx;
          wr_data_d = in_data;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + IW'(1);
            end
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end

      // wr_en_q still carries the last element's enable during this cycle
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= S_IDLE;
      reg_clear_q <= 1'b0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_clear_q <= reg_clear_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_CLR) || (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign reg_clear = reg_clear_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign row       = row_q;
  assign col       = col_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Testbench for matrix_load_ctrl: a 2x2 instance driven by directed streams
// and a 1x1 instance. Expected bank-side events are queued by the stimulus
// and consumed by per-instance monitors on the falling edge.
module tb_matrix_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2x2 instance
  logic       clear, start, abort, in_valid, in_ready;
  logic [7:0] in_data;
  logic       reg_clear, busy, done;
  logic [3:0] wr_en;
  logic [7:0] wr_data;
  logic [1:0] row, col;

  // 1x1 instance
  logic       start1, abort1, in_valid1, in_ready1;
  logic [7:0] in_data1;
  logic       reg_clear1, busy1, done1;
  logic [0:0] wr_en1;
  logic [7:0] wr_data1;
  logic [0:0] row1, col1;

  matrix_load_ctrl #(.ROWS(2), .COLS(2)) u_dut (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reg_clear(reg_clear), .wr_en(wr_en), .wr_data(wr_data),
    .row(row), .col(col), .busy(busy), .done(done)
  );

  matrix_load_ctrl #(.ROWS(1), .COLS(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .abort(abort1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .reg_clear(reg_clear1), .wr_en(wr_en1), .wr_data(wr_data1),
    .row(row1), .col(col1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic       rc;
    logic       dn;
    logic [3:0] we;
    logic [7:0] wd;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t e0, e1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_wr0 = -100;
  int last_wr1 = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // model of the register bank fed by the 2x2 loader
  logic [7:0] bank [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reg_clear)     bank[i] <= 8'h00;
      else if (wr_en[i]) bank[i] <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic rc, input logic dn, input logic [3:0] we, input logic [7:0] wd);
    q0.push_back(ev_t'{rc, dn, we, wd});
  endtask

  task automatic push1(input logic rc, input logic dn, input logic [3:0] we, input logic [7:0] wd);
    q1.push_back(ev_t'{rc, dn, we, wd});
  endtask

  // clear pulse, four row-major writes, done
  task automatic expect_load0(input logic [31:0] data);
    push0(1'b1, 1'b0, 4'b0000, 8'h00);
    push0(1'b0, 1'b0, 4'b0001, data[7:0]);
    push0(1'b0, 1'b0, 4'b0010, data[15:8]);
    push0(1'b0, 1'b0, 4'b0100, data[23:16]);
    push0(1'b0, 1'b0, 4'b1000, data[31:24]);
    push0(1'b0, 1'b1, 4'b0000, 8'h00);
  endtask

  // start, then present in_valid per pattern bit once the loader is in LOAD;
  // start_at >= 0 re-pulses start during that LOAD cycle
  task automatic run_load0(input logic [31:0] data, input logic [15:0] pat,
                           input int plen, input int start_at);
    int k;
    k = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < plen; i++) begin
      in_valid = pat[i];
      in_data  = data[8*k +: 8];
      start    = (i == start_at);
      if (pat[i]) k++;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic drain0(input string name);
    for (int i = 0; i < 20 && q0.size() != 0; i++) tick();
    chk(name, 32'(q0.size()), 32'd0);
    tick();
  endtask

  task automatic check_bank(input string name, input logic [31:0] data);
    for (int i = 0; i < 4; i++) chk(name, 32'(bank[i]), 32'(data[8*i +: 8]));
  endtask

  // monitor for the 2x2 instance
  always @(negedge clk) begin
    chk("onehot0", 32'($onehot0(wr_en)), 32'd1);
    if (reg_clear || done || wr_en != 4'b0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected: got rc=%b done=%b wr_en=%b, required no event",
                 reg_clear, done, wr_en);
      end else begin
        e0 = q0.pop_front();
        chk("sb0_reg_clear", 32'(reg_clear), 32'(e0.rc));
        chk("sb0_done", 32'(done), 32'(e0.dn));
        chk("sb0_wr_en", 32'(wr_en), 32'(e0.we));
        if (e0.we != 4'b0) chk("sb0_wr_data", 32'(wr_data), 32'(e0.wd));
        if (e0.dn) chk("sb0_done_gap", 32'(cyc - last_wr0), 32'd1);
      end
      if (wr_en != 4'b0) last_wr0 = cyc;
    end
  end

  // monitor for the 1x1 instance
  always @(negedge clk) begin
    if (reg_clear1 || done1 || wr_en1 != 1'b0) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got rc=%b done=%b wr_en=%b, required no event",
                 reg_clear1, done1, wr_en1);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_reg_clear", 32'(reg_clear1), 32'(e1.rc));
        chk("sb1_done", 32'(done1), 32'(e1.dn));
        chk("sb1_wr_en", 32'(wr_en1), 32'(e1.we));
        if (e1.we != 4'b0) chk("sb1_wr_data", 32'(wr_data1), 32'(e1.wd));
        if (e1.dn) chk("sb1_done_gap", 32'(cyc - last_wr1), 32'd1);
      end
      if (wr_en1 != 1'b0) last_wr1 = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    start1 = 1'b0; abort1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00;
    repeat (3) tick();
    clear = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // 1: clear held 3 cycles in the middle of a load
    push0(1'b1, 1'b0, 4'b0000, 8'h00);
    push0(1'b0, 1'b0, 4'b0001, 8'hAA);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_data = 8'hBB; clear = 1'b1;
    repeat (3) tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_reg_clear", 32'(reg_clear), 32'd0);
    chk("clr_wr_en", 32'(wr_en), 32'd0);
    chk("clr_wr_data", 32'(wr_data), 32'd0);
    chk("clr_row", 32'(row), 32'd0);
    chk("clr_col", 32'(col), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_sb_empty", 32'(q0.size()), 32'd0);
    tick();

    // 2: back-to-back stream
    expect_load0(32'h44332211);
    run_load0(32'h44332211, 16'b1111, 4, -1);
    drain0("b2b_drain");
    check_bank("b2b_bank", 32'h44332211);
    chk("b2b_idle", 32'(busy), 32'd0);

    // 3: gapped in_valid 1,0,0,1,1,0,1
    expect_load0(32'h44332211);
    run_load0(32'h44332211, 16'b1011001, 7, -1);
    drain0("gap_drain");
    check_bank("gap_bank", 32'h44332211);

    // 4: abort after two beats, with a beat offered in the abort cycle
    push0(1'b1, 1'b0, 4'b0000, 8'h00);
    push0(1'b0, 1'b0, 4'b0001, 8'h5A);
    push0(1'b0, 1'b0, 4'b0010, 8'h6B);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h5A; tick();
    in_data = 8'h6B; tick();
    chk("abort_pre_row", 32'(row), 32'd1);
    chk("abort_pre_col", 32'(col), 32'd0);
    in_data = 8'h7C; abort = 1'b1; tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_row", 32'(row), 32'd0);
    chk("abort_col", 32'(col), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    chk("abort_sb_empty", 32'(q0.size()), 32'd0);
    chk("abort_bank_kept", 32'(bank[1]), 32'h6B);
    expect_load0(32'hD4C3B2A1);
    run_load0(32'hD4C3B2A1, 16'b1111, 4, -1);
    drain0("restart_drain");
    check_bank("restart_bank", 32'hD4C3B2A1);

    // 5: start during LOAD and during DONE is ignored; later start reloads
    expect_load0(32'h08070605);
    run_load0(32'h08070605, 16'b1111, 4, 1);
    tick();
    chk("s5_done", 32'(done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("s5_idle_busy", 32'(busy), 32'd0);
    chk("s5_no_reg_clear", 32'(reg_clear), 32'd0);
    tick();
    chk("s5_sb_empty", 32'(q0.size()), 32'd0);
    check_bank("s5_bank", 32'h08070605);
    expect_load0(32'h0D0C0B0A);
    run_load0(32'h0D0C0B0A, 16'b1111, 4, -1);
    drain0("s5_reload_drain");
    check_bank("s5_reload_bank", 32'h0D0C0B0A);

    // 6: 1x1 matrix, single beat
    push1(1'b1, 1'b0, 4'b0000, 8'h00);
    push1(1'b0, 1'b0, 4'b0001, 8'hA5);
    push1(1'b0, 1'b1, 4'b0000, 8'h00);
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    chk("s6_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_data1 = 8'hA5; tick();
    in_valid1 = 1'b0;
    for (int i = 0; i < 20 && q1.size() != 0; i++) tick();
    chk("s6_drain", 32'(q1.size()), 32'd0);
    tick();
    chk("s6_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
